// File: rtl/pwm_pkg.sv
// Shared constants and types for the multi-channel PWM block.
package pwm_pkg;

  localparam int DEF_CHANNELS  = 4;
  localparam int DEF_CNT_W     = 8;
  localparam int DEF_PERIOD    = 10;
  localparam int DEF_DUTY_INIT = 5;
  localparam int DEF_DEB_DIV   = 2;

  typedef enum logic {
    UP   = 1'b0,
    DOWN = 1'b1
  } cnt_dir_e;

endpackage

// File: rtl/pwm_debounce.sv
// Tick-sampled two-flop button synchroniser producing one event per press.
module pwm_debounce
  import pwm_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic raw,
  output logic evt
);

  logic s1;
  logic s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else if (tick) begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // rising edge seen between the last two ticks, qualified so it lasts one cycle
  assign evt = s1 & ~s2 & tick;

endmodule

// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM with debounced duty buttons and period-synchronous duty update.
// Define PWM_CENTER_ALIGN_EN for an up/down (center-aligned) counter of 2*PERIOD cycles.
module pwm_multi_channel
  import pwm_pkg::*;
#(
  parameter int CHANNELS  = DEF_CHANNELS,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int PERIOD    = DEF_PERIOD,
  parameter int DUTY_INIT = DEF_DUTY_INIT,
  parameter int DEB_DIV   = DEF_DEB_DIV
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       inc_duty,
  input  logic [CHANNELS-1:0]       dec_duty,
  output logic [CHANNELS-1:0]       pwm_out,
  output logic                      period_tick,
  output logic [CHANNELS*CNT_W-1:0] duty_o
);

  localparam int DEB_W = (DEB_DIV > 1) ? $clog2(DEB_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_TOP   = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] DUTY_MAX  = CNT_W'(PERIOD);
  localparam logic [CNT_W-1:0] DUTY_RST  = CNT_W'(DUTY_INIT);
  localparam logic [DEB_W-1:0] DEB_TOP   = DEB_W'(DEB_DIV - 1);

  if (DUTY_INIT > PERIOD || PERIOD >= 2**CNT_W || PERIOD < 2 || DEB_DIV < 1 || CHANNELS < 1)
  begin : g_bad_params
    $error("pwm_multi_channel: illegal parameter combination");
  end

  logic [DEB_W-1:0] deb_cnt;
  logic             deb_tick;
  logic [CNT_W-1:0] cnt;

  assign deb_tick = (deb_cnt == DEB_TOP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        deb_cnt <= '0;
    else if (deb_tick) deb_cnt <= '0;
    else               deb_cnt <= deb_cnt + 1'b1;
  end

`ifdef PWM_CENTER_ALIGN_EN
  cnt_dir_e dir;

  // both turning points are held for one extra cycle so a full period is 2*PERIOD
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      dir <= UP;
    end else if (dir == UP) begin
      if (cnt == CNT_TOP) dir <= DOWN;
      else                cnt <= cnt + 1'b1;
    end else begin
      if (cnt == '0) dir <= UP;
      else           cnt <= cnt - 1'b1;
    end
  end

  assign period_tick = (dir == DOWN) && (cnt == '0);
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               cnt <= '0;
    else if (cnt == CNT_TOP)  cnt <= '0;
    else                      cnt <= cnt + 1'b1;
  end

  assign period_tick = (cnt == CNT_TOP);
`endif

  logic [CHANNELS-1:0] inc_evt;
  logic [CHANNELS-1:0] dec_evt;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [CNT_W-1:0] pend;
    logic [CNT_W-1:0] act;
    logic             pwm_q;

    pwm_debounce u_inc (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (deb_tick),
      .raw   (inc_duty[i]),
      .evt   (inc_evt[i])
    );

    pwm_debounce u_dec (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (deb_tick),
      .raw   (dec_duty[i]),
      .evt   (dec_evt[i])
    );

    // active duty only moves at period end, so an edit never cuts a pulse short
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pend  <= DUTY_RST;
        act   <= DUTY_RST;
        pwm_q <= 1'b0;
      end else begin
        if (inc_evt[i] && !dec_evt[i] && pend != DUTY_MAX)
          pend <= pend + 1'b1;
        else if (dec_evt[i] && !inc_evt[i] && pend != '0)
          pend <= pend - 1'b1;
        if (period_tick) act <= pend;
        pwm_q <= (cnt < act);
      end
    end

    assign pwm_out[i]                = pwm_q;
    assign duty_o[i*CNT_W +: CNT_W]  = act;
  end

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Randomised and directed bench for pwm_multi_channel against a cycle-count reference model.
module tb_pwm_multi_channel;

  localparam int CH = 4;
  localparam int W  = 8;
  localparam int P  = 10;
  localparam int DI = 5;
  localparam int DD = 2;
`ifdef PWM_CENTER_ALIGN_EN
  localparam int LEN = 2 * P;
`else
  localparam int LEN = P;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [CH-1:0]   inc_duty = '0;
  logic [CH-1:0]   dec_duty = '0;
  logic [CH-1:0]   pwm_out;
  logic            period_tick;
  logic [CH*W-1:0] duty_o;

  pwm_multi_channel #(
    .CHANNELS(CH), .CNT_W(W), .PERIOD(P), .DUTY_INIT(DI), .DEB_DIV(DD)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .inc_duty    (inc_duty),
    .dec_duty    (dec_duty),
    .pwm_out     (pwm_out),
    .period_tick (period_tick),
    .duty_o      (duty_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // reference: k = cycles since reset release; counter value and tick follow from k alone
  int k;
  int pend[CH], act[CH], m_pwm[CH];
  int last_i[CH], prev_i[CH], last_d[CH], prev_d[CH];
  int hi_cnt[CH];
  int pt_cnt;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int cnt_of(input int kk);
    int p;
    p = kk % LEN;
    return (p < P) ? p : LEN - 1 - p;
  endfunction

  function automatic int ptick_of(input int kk);
    return ((kk % LEN) == LEN - 1) ? 1 : 0;
  endfunction

  task automatic model_reset();
    k = 0;
    for (int c = 0; c < CH; c++) begin
      pend[c] = DI; act[c] = DI; m_pwm[c] = 0;
      last_i[c] = 0; prev_i[c] = 0; last_d[c] = 0; prev_d[c] = 0;
    end
  endtask

  task automatic model_step(input logic [CH-1:0] i_v, input logic [CH-1:0] d_v);
    int tick, ie, de;
    tick = ((k % DD) == DD - 1) ? 1 : 0;
    for (int c = 0; c < CH; c++) begin
      m_pwm[c] = (cnt_of(k) < act[c]) ? 1 : 0;
      if (ptick_of(k) == 1) act[c] = pend[c];
      ie = tick & last_i[c] & (1 - prev_i[c]);
      de = tick & last_d[c] & (1 - prev_d[c]);
      if (ie == 1 && de == 0)      pend[c] = (pend[c] + 1 > P) ? P : pend[c] + 1;
      else if (de == 1 && ie == 0) pend[c] = (pend[c] - 1 < 0) ? 0 : pend[c] - 1;
      if (tick == 1) begin
        prev_i[c] = last_i[c]; last_i[c] = int'(i_v[c]);
        prev_d[c] = last_d[c]; last_d[c] = int'(d_v[c]);
      end
    end
    k++;
  endtask

  // entered and left at a negedge
  task automatic cycle(input logic [CH-1:0] i_v, input logic [CH-1:0] d_v);
    for (int c = 0; c < CH; c++) begin
      check($sformatf("pwm%0d", c), int'(pwm_out[c]), m_pwm[c]);
      check($sformatf("duty%0d", c), int'(duty_o[c*W +: W]), act[c]);
      hi_cnt[c] += int'(pwm_out[c]);
    end
    check("period_tick", int'(period_tick), ptick_of(k));
    pt_cnt += int'(period_tick);
    inc_duty = i_v;
    dec_duty = d_v;
    model_step(i_v, d_v);
    @(negedge clk);
  endtask

  task automatic run(input int n, input logic [CH-1:0] i_v, input logic [CH-1:0] d_v);
    for (int j = 0; j < n; j++) cycle(i_v, d_v);
  endtask

  task automatic press(input int ch, input bit up, input bit down);
    logic [CH-1:0] m;
    m = '0;
    m[ch] = 1'b1;
    run(4, up ? m : '0, down ? m : '0);
    run(4, '0, '0);
  endtask

  task automatic clear_window();
    for (int c = 0; c < CH; c++) hi_cnt[c] = 0;
    pt_cnt = 0;
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_pwm"}, int'(pwm_out), 0);
    check({tag, "_ptick"}, int'(period_tick), 0);
    for (int c = 0; c < CH; c++)
      check($sformatf("%s_duty%0d", tag, c), int'(duty_o[c*W +: W]), DI);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    inc_duty = '0;
    dec_duty = '0;
    #1;
    reset_checks("rst_now");
    @(negedge clk);
    @(negedge clk);
    reset_checks("rst_hold");
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [CH-1:0] ri, rd;
    int guard;
    model_reset();
    clear_window();
    @(negedge clk);
    reset_checks("rst_init");
    rst_n = 1'b1;

    // idle operation: half duty, one tick per period
    run(3 * LEN, '0, '0);
    clear_window();
    run(LEN, '0, '0);
    check("idle_hi0", hi_cnt[0], DI * LEN / P);
    check("idle_hi3", hi_cnt[3], DI * LEN / P);
    check("idle_ticks", pt_cnt, 1);

    // pending edit on ch3 then reset mid-period at count 3
    guard = 0;
    while (cnt_of(k) != P - 1 && guard < 4 * LEN) begin cycle('0, '0); guard++; end
    while (cnt_of(k) != 3 && guard < 8 * LEN) begin cycle(4'b1000, '0); guard++; end
    check("mid_guard", int'(guard < 8 * LEN), 1);
    do_reset();
    run(3 * LEN, '0, '0);
    check("post_rst_duty3", int'(duty_o[3*W +: W]), DI);

    // long hold on ch1 gives exactly one increment
    run(20, 4'b0010, '0);
    run(3 * LEN, '0, '0);
    check("hold_duty1", int'(duty_o[1*W +: W]), DI + 1);

    // simultaneous inc/dec on ch2 cancels
    press(2, 1'b1, 1'b1);
    run(2 * LEN, '0, '0);
    check("both_duty2", int'(duty_o[2*W +: W]), DI);

    // dec saturation at 0
    do_reset();
    for (int n = 0; n < 6; n++) press(0, 1'b0, 1'b1);
    run(2 * LEN, '0, '0);
    check("dec_sat_duty0", int'(duty_o[W-1:0]), 0);
    clear_window();
    run(LEN, '0, '0);
    check("dec_sat_hi0", hi_cnt[0], 0);

    // inc saturation at PERIOD
    do_reset();
    for (int n = 0; n < 7; n++) press(0, 1'b1, 1'b0);
    run(2 * LEN, '0, '0);
    check("inc_sat_duty0", int'(duty_o[W-1:0]), P);
    clear_window();
    run(LEN, '0, '0);
    check("inc_sat_hi0", hi_cnt[0], LEN);

    // random button activity against the model
    for (int n = 0; n < 150; n++) begin
      ri = CH'($urandom_range(0, (1 << CH) - 1));
      rd = CH'($urandom_range(0, (1 << CH) - 1));
      run($urandom_range(1, 6), ri, rd);
    end
    run(2 * LEN, '0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pwm_multi_channel.md
PWM_MULTI_CHANNEL -- requirements
Module: pwm_multi_channel

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- CHANNELS, 4, number of independent PWM channels.
- CNT_W, 8, width of the period counter and duty registers.
- PERIOD, 10, clock cycles per PWM period (edge-aligned).
- DUTY_INIT, 5, duty value loaded at reset, in counts.
- DEB_DIV, 2, clock cycles between debounce sample ticks.

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single clock.
- rst_n, in, 1, reset: asynchronous assert, active-low.
- inc_duty, in, CHANNELS, per-channel raw button that increases duty.
- dec_duty, in, CHANNELS, per-channel raw button that decreases duty.
- pwm_out, out, CHANNELS, registered PWM outputs.
- period_tick, out, 1, one-cycle pulse on the last cycle of each period.
- duty_o, out, CHANNELS*CNT_W, active duty values, channel 0 in the LSBs.

Function
REQ-003 A debounce divider SHALL count 0..DEB_DIV-1 and assert tick on count DEB_DIV-1.
REQ-004 Each channel SHALL sample inc and dec through two flops, enabled only on tick: s1<=in, s2<=s1.
REQ-005 An inc or dec event SHALL be s1 & ~s2 & tick: at most one event per press, regardless of hold time.
REQ-006 On an inc event, the pending duty SHALL become min(pending+1, PERIOD).
REQ-007 On a dec event, the pending duty SHALL become max(pending-1, 0).
REQ-008 Saturation SHALL hold at PERIOD and at 0; the counter SHALL never wrap.
REQ-009 Simultaneous inc and dec events on one channel SHALL leave the pending duty unchanged.
REQ-010 The shared period counter SHALL count 0..PERIOD-1 and then wrap to 0.
REQ-011 period_tick SHALL be high exactly when the counter equals PERIOD-1.
REQ-012 On period_tick, the active duty SHALL load from the pending duty.
REQ-013 A duty change SHALL never alter the current period: no glitches and no runt pulses.
REQ-014 pwm_out[i] SHALL be registered as (cnt < active_duty[i]), giving one cycle of latency after the counter.
REQ-015 A duty of 0 SHALL give a constant-low output.
REQ-016 A duty of PERIOD SHALL give a constant-high output.
REQ-017 duty_o SHALL reflect the active duty, not the pending duty.
REQ-018 Elaboration SHALL fail if any of the following hold:
- DUTY_INIT > PERIOD;
- PERIOD >= 2**CNT_W;
- PERIOD < 2;
- DEB_DIV < 1;
- CHANNELS < 1.

Reset
REQ-019 While rst_n is low, the following SHALL be 0: pwm_out, period_tick, the period counter, the divider, and all sampler flops.
REQ-020 While rst_n is low, every pending and active duty SHALL equal DUTY_INIT.
REQ-021 Reset asserted mid-period SHALL abort the period immediately and discard pending changes.
REQ-022 After reset release, the first counter value SHALL be 0 on the first clk edge.

Configuration
REQ-023 With PWM_CENTER_ALIGN_EN defined, the counter SHALL count up 0..PERIOD-1 and then down PERIOD-1..0, for a period of 2*PERIOD cycles.
REQ-024 In center-aligned mode, period_tick SHALL fire on the cycle the down-count reaches 0, and the output rule of REQ-014 SHALL still apply.
REQ-025 In center-aligned mode, pulses SHALL be centred on the count-0 cycles.
REQ-026 Without PWM_CENTER_ALIGN_EN, the block SHALL be edge-aligned per REQ-010, and no direction flop SHALL exist.

Structure
REQ-027 Package pwm_pkg SHALL hold the default parameter constants and the count-direction typedef (UP, DOWN) used under the macro.
REQ-028 Sub-module pwm_debounce SHALL implement REQ-004 and REQ-005 for one input, and SHALL be instantiated 2*CHANNELS times.
REQ-029 The shared divider and the period counter SHALL live in the top level.

Verification (defaults, edge-aligned unless stated)
REQ-030 Reset release with no presses: each pwm_out is high 5 of every 10 cycles, period_tick pulses every 10 cycles, and duty_o reads 5 on every channel.
REQ-031 Hold inc_duty[1] for 20 cycles: exactly one event occurs, duty_o[1] becomes 6 at the next period_tick, and the current period stays at 5 high.
REQ-032 Issue 7 separate inc presses on channel 0: duty saturates at 10 and pwm_out[0] is constant high.
REQ-033 Issue 6 separate dec presses on channel 0: duty reaches 0 and pwm_out[0] is constant low.
REQ-034 Press inc and dec together on channel 2: duty stays 5.
REQ-035 Pull rst_n low at count 3: all outputs are 0 at once, and after release duty is 5 with no leftover edit.
REQ-036 With PWM_CENTER_ALIGN_EN and duty 5: the period is 20 cycles, the output is high for 10, centred on the count-0 cycles.
